// File: rtl/countdown_sequencer.sv
// ============================================================================
// countdown_sequencer
//
// Pre-round countdown display driver for the Simon Says seven-segment front
// end. A rising edge on start launches a descending count (COUNT_FROM down to
// 1) on digit 0, followed by a two-glyph "GO" frame on digits 1:0. Each frame
// is held for HOLD_TICKS timebase ticks. When the GO frame expires, done
// pulses for one cycle to hand control to the game FSM.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   tick    in   single-cycle timebase enable from the prescaler
//   start   in   start request, rising edge triggers (only while idle)
//   abort   in   level-sensitive cancel, highest priority
//   digits  out  packed 4-bit glyph codes, digit i at [4i+3:4i]
//   blank   out  per-digit blank mask, 1 = digit dark
//   busy    out  sequence in progress
//   frame   out  current frame index (0 idle, 1..COUNT_FROM, COUNT_FROM+1 = GO)
//   done    out  one-cycle pulse as the GO frame completes
// ============================================================================
module countdown_sequencer #(
    parameter int         DIGITS     = 4,
    parameter int         COUNT_FROM = 3,
    parameter int         HOLD_TICKS = 4,
    parameter logic [3:0] GO_HI      = 4'hB,
    parameter logic [3:0] GO_LO      = 4'hE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  abort,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic [3:0]            frame,
    output logic                  done
);

    // Reject parameter values the display mux and counters cannot represent.
    generate
        if (DIGITS < 2) begin : gBadDigits
            $error("countdown_sequencer: DIGITS must be at least 2");
        end
        if (COUNT_FROM < 1 || COUNT_FROM > 14) begin : gBadCountFrom
            $error("countdown_sequencer: COUNT_FROM must be in 1..14");
        end
        if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : gBadHoldTicks
            $error("countdown_sequencer: HOLD_TICKS must be in 1..255");
        end
    endgenerate

    localparam logic [3:0]          FIRST_VALUE = 4'(COUNT_FROM);
    localparam logic [3:0]          GO_FRAME    = 4'(COUNT_FROM + 1);
    localparam logic [7:0]          HOLD_LAST   = 8'(HOLD_TICKS - 1);
    localparam logic [DIGITS-1:0]   BLANK_ALL   = '1;
    localparam logic [DIGITS-1:0]   BLANK_COUNT = BLANK_ALL << 1;
    localparam logic [DIGITS-1:0]   BLANK_GO    = BLANK_ALL << 2;
    localparam logic [4*DIGITS-1:0] GO_DIGITS   = (4*DIGITS)'({GO_HI, GO_LO});

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        GO
    } stateType;

    stateType              r_state;
    logic [3:0]            r_value;
    logic [7:0]            r_holdCount;
    logic                  r_startQ;
    logic                  r_startArmed;
    logic [4*DIGITS-1:0]   r_digits;
    logic [DIGITS-1:0]     r_blank;
    logic                  r_busy;
    logic [3:0]            r_frame;
    logic                  r_done;

    logic                  w_startEdge;
    logic                  w_holdDone;

    // A start edge is only meaningful once the first post-reset clock has
    // captured the start level; a level already high at reset release must
    // not look like a fresh request.
    assign w_startEdge = start & ~r_startQ & r_startArmed;

    // The current frame has been shown for its full hold time on this tick.
    assign w_holdDone = (r_holdCount == HOLD_LAST);

    assign digits = r_digits;
    assign blank  = r_blank;
    assign busy   = r_busy;
    assign frame  = r_frame;
    assign done   = r_done;

    // Sequencer FSM. Display and status registers are loaded on the same edge
    // as the state change, so they always describe the state just entered.
    // Abort is checked first so it overrides ticks, start edges and hold
    // expiry; the start history still updates so an edge swallowed by abort
    // is not seen again later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_value      <= '0;
            r_holdCount  <= '0;
            r_startQ     <= 1'b0;
            r_startArmed <= 1'b0;
            r_digits     <= '0;
            r_blank      <= BLANK_ALL;
            r_busy       <= 1'b0;
            r_frame      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_startQ     <= start;
            r_startArmed <= 1'b1;
            r_done       <= 1'b0;

            if (abort) begin
                r_state     <= IDLE;
                r_value     <= '0;
                r_holdCount <= '0;
                r_digits    <= '0;
                r_blank     <= BLANK_ALL;
                r_busy      <= 1'b0;
                r_frame     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_startEdge) begin
                            r_state     <= COUNT;
                            r_value     <= FIRST_VALUE;
                            r_holdCount <= '0;
                            r_digits    <= (4*DIGITS)'(FIRST_VALUE);
                            r_blank     <= BLANK_COUNT;
                            r_busy      <= 1'b1;
                            r_frame     <= 4'd1;
                        end
                    end

                    COUNT: begin
                        if (tick) begin
                            if (w_holdDone) begin
                                r_holdCount <= '0;
                                if (r_value == 4'd1) begin
                                    r_state  <= GO;
                                    r_value  <= '0;
                                    r_digits <= GO_DIGITS;
                                    r_blank  <= BLANK_GO;
                                    r_frame  <= GO_FRAME;
                                end else begin
                                    r_value  <= r_value - 4'd1;
                                    r_digits <= (4*DIGITS)'(r_value - 4'd1);
                                    r_frame  <= r_frame + 4'd1;
                                end
                            end else begin
                                r_holdCount <= r_holdCount + 8'd1;
                            end
                        end
                    end

                    GO: begin
                        if (tick) begin
                            if (w_holdDone) begin
                                r_state     <= IDLE;
                                r_holdCount <= '0;
                                r_digits    <= '0;
                                r_blank     <= BLANK_ALL;
                                r_busy      <= 1'b0;
                                r_frame     <= '0;
                                r_done      <= 1'b1;
                            end else begin
                                r_holdCount <= r_holdCount + 8'd1;
                            end
                        end
                    end

                    default: begin
                        r_state     <= IDLE;
                        r_value     <= '0;
                        r_holdCount <= '0;
                        r_digits    <= '0;
                        r_blank     <= BLANK_ALL;
                        r_busy      <= 1'b0;
                        r_frame     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Parametrised pre-round countdown display driver for the Simon Says seven-segment front end. On a start request it shows a descending digit count (COUNT_FROM down to 1), then a two-glyph "GO" frame, each frame held for a programmable number of tick pulses. It then pulses done to hand control to the game FSM. Outputs are packed 4-bit glyph codes plus a per-digit blank mask, feeding the existing display mux/decoder.

Parameters:
DIGITS, 4, number of display digits driven (2..8); digit 0 is rightmost.
COUNT_FROM, 3, first count value shown (1..14).
HOLD_TICKS, 4, tick pulses each frame is held (1..255).
GO_HI, 4'hB, glyph code placed on digit 1 during the GO frame.
GO_LO, 4'hE, glyph code placed on digit 0 during the GO frame.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  single-cycle timebase enable from the prescaler
start  in  1  start request; a rising edge is the trigger
abort  in  1  cancel sequence, level-sensitive, sampled on clk
digits  out  4*DIGITS  packed glyph codes; digit i occupies bits [4i+3:4i]
blank  out  DIGITS  1 = digit i dark
busy  out  1  sequence in progress
frame  out  4  current frame index
done  out  1  one-cycle pulse when the GO frame completes

Behaviour:
- Reset (async, active-high; clock clk): state IDLE, digits=0, blank=all ones, busy=0, frame=0, done=0, hold count=0, start_q=0.
- All outputs are registered. Display and status outputs reflect the state one cycle after the transition edge.
- Start edge: start & ~start_q, where start_q is a registered copy of start. Only accepted in IDLE. Edges while busy are ignored, not queued.
- State IDLE: blank all ones, digits 0, busy 0, frame 0. On a start edge, go to COUNT with value=COUNT_FROM and hold=0.
- State COUNT:
  - digit 0 = value; all other digits blank and 0; busy 1.
  - frame = COUNT_FROM - value + 1 (1..COUNT_FROM).
  - On each tick: if hold==HOLD_TICKS-1, set hold to 0 and advance; otherwise increment hold.
  - Advance: if value==1, go to GO; otherwise decrement value.
- State GO:
  - digit1=GO_HI, digit0=GO_LO, upper digits blank; frame=COUNT_FROM+1; busy 1.
  - After HOLD_TICKS ticks, go to IDLE and assert done for exactly one cycle, coincident with busy falling.
- Total duration from start acceptance to done: (COUNT_FROM+1)*HOLD_TICKS ticks. Ticks that arrive between ticks' edges do not count.
- Ticks are counted only in COUNT and GO. A tick in the same cycle as an accepted start edge is not counted.
- Abort has the highest priority over tick, start and hold expiry. In any state it returns to IDLE next cycle, clears hold, and does not assert done. If abort is held high while start rises, that start edge is discarded.
- HOLD_TICKS=1: every tick advances one frame.
- COUNT_FROM=1: a single count frame "1", then GO.
- Reset mid-sequence: immediate return to IDLE values with no done pulse. A start held high across reset release does not trigger, because start_q resets to 0 and requires a fresh edge… the rule is that the first edge after release is required: start_q captures the level on the first clock, so a level already high produces no edge.
- Elaboration check: DIGITS<2, COUNT_FROM outside 1..14, or HOLD_TICKS outside 1..255 is an error.
- Unused digit codes are driven 0, never X.

Test Plan:
- Defaults, start pulse, tick every 10 cycles -> digit0 shows 3,2,1 for 4 ticks each, then digits[7:0]=8'hBE with blank=4'b1100 for 4 ticks. done is high for 1 cycle after the 16th tick; busy drops in the same cycle; blank returns to 4'b1111.
- Abort asserted after 6 ticks (digit0=2, frame=2) -> next cycle IDLE, blank=4'b1111, frame=0, no done. A new start pulse restarts at 3.
- Second start pulse during COUNT, and start held high continuously -> sequence unaffected; only one done. No retrigger until start falls and rises again.
- start and tick in the same cycle in IDLE, then DIGITS=6, COUNT_FROM=5, HOLD_TICKS=1 -> first tick is not counted; frames 5,4,3,2,1,GO on successive ticks; blank=6'b111110 during count; done after 6 counted ticks.
- reset asserted asynchronously mid-GO frame -> outputs reach their reset values without waiting for clk. Deassert with start low, then pulse start -> normal sequence from 3.
- Tick held high continuously (every cycle) with defaults -> done exactly 16 cycles after busy rises; frame steps 1,2,3,4 every 4 cycles.
